rob_retire_queue: RTL and testbench

- In-order reorder buffer that sits directly downstream of register rename.
- Each cycle it accepts at most one renamed instruction (new phys dest, previous phys mapping, arch dest, store flag) and returns a ROB tag.
- It marks entries done from up to two completion reports per cycle.
- It retires up to two done entries per cycle in program order. Each retire slot returns the superseded physical register to the rename free list through the retire_valid1/2 and retire_phys_reg1/2 pairs.

---
 rtl/rob_retire_queue_pkg.sv | 20 ++
 rtl/rob_retire_queue_if.sv | 43 ++++
 rtl/rob_retire_queue.sv | 113 +++++++++++
 tb/tb_rob_retire_queue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_retire_queue_pkg.sv
// Shared constants and the reorder-buffer entry layout used by the retire queue.
// Physical register 6'h3f is reserved as the "no destination" marker.
package rob_retire_queue_pkg;
  localparam int PHYS_W    = 6;
  localparam int ARCH_W    = 5;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = 4;

  localparam logic [PHYS_W-1:0] NO_REG    = 6'b111111;
  localparam logic [ARCH_W-1:0] ARCH_NONE = 5'b11111;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              is_store;
    logic [PHYS_W-1:0] phys_rd;
    logic [PHYS_W-1:0] old_phys_rd;
    logic [ARCH_W-1:0] arch_reg;
  } rob_entry_t;
endpackage

// File: rtl/rob_retire_queue_if.sv
// Allocation, completion, retire and status signals of the reorder buffer.
// The slave side is the ROB itself; the master side is rename/execute.
interface rob_retire_queue_if
  import rob_retire_queue_pkg::*;
#(
  parameter int TAG_W = ROB_TAG_W
) ();
  logic              alloc_valid;
  logic [PHYS_W-1:0] alloc_phys_rd;
  logic [PHYS_W-1:0] alloc_old_phys_rd;
  logic [ARCH_W-1:0] alloc_arch_reg;
  logic              alloc_is_store;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              complete_valid1;
  logic [TAG_W-1:0]  complete_tag1;
  logic              complete_valid2;
  logic [TAG_W-1:0]  complete_tag2;
  logic              retire_valid1;
  logic [PHYS_W-1:0] retire_phys_reg1;
  logic              retire_valid2;
  logic [PHYS_W-1:0] retire_phys_reg2;
  logic [1:0]        retire_count;
  logic [TAG_W:0]    rob_count;
  logic              rob_empty;
  logic              rob_full;

  modport slave (
    input  alloc_valid, alloc_phys_rd, alloc_old_phys_rd, alloc_arch_reg, alloc_is_store,
    input  complete_valid1, complete_tag1, complete_valid2, complete_tag2,
    output alloc_ready, alloc_tag,
    output retire_valid1, retire_phys_reg1, retire_valid2, retire_phys_reg2, retire_count,
    output rob_count, rob_empty, rob_full
  );

  modport master (
    output alloc_valid, alloc_phys_rd, alloc_old_phys_rd, alloc_arch_reg, alloc_is_store,
    output complete_valid1, complete_tag1, complete_valid2, complete_tag2,
    input  alloc_ready, alloc_tag,
    input  retire_valid1, retire_phys_reg1, retire_valid2, retire_phys_reg2, retire_count,
    input  rob_count, rob_empty, rob_full
  );
endinterface

// File: rtl/rob_retire_queue.sv
// In-order reorder buffer: one allocation, two completions and up to two
// in-order retirements per cycle; retirements free the superseded phys register.
module rob_retire_queue
  import rob_retire_queue_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W
) (
  input logic               clk,
  input logic               reset,
  rob_retire_queue_if.slave bus
);
  rob_entry_t        entries_reg  [DEPTH];
  rob_entry_t        entries_next [DEPTH];
  logic [TAG_W-1:0]  head_reg, head_next, head_plus1;
  logic [TAG_W-1:0]  tail_reg, tail_next;
  logic [TAG_W:0]    count_reg, count_next;
  logic              full, alloc_fire, r1, r2;
  logic [1:0]        retire_num;
  logic              free1, free2;
  logic              retire_valid1_reg, retire_valid2_reg;
  logic [PHYS_W-1:0] retire_phys1_reg, retire_phys2_reg;
  logic [1:0]        retire_count_reg;

  assign head_plus1 = head_reg + TAG_W'(1);
  assign full       = (count_reg == (TAG_W+1)'(DEPTH));
  assign alloc_fire = bus.alloc_valid && !full;

  // Retire decision sees only done bits already registered, so a completion
  // arriving this cycle cannot retire until the next one.
  assign r1 = entries_reg[head_reg].valid && entries_reg[head_reg].done;
  assign r2 = r1 && entries_reg[head_plus1].valid && entries_reg[head_plus1].done;
  assign retire_num = {1'b0, r1} + {1'b0, r2};

  assign free1 = r1 && !entries_reg[head_reg].is_store
                    && (entries_reg[head_reg].old_phys_rd != NO_REG);
  assign free2 = r2 && !entries_reg[head_plus1].is_store
                    && (entries_reg[head_plus1].old_phys_rd != NO_REG);

  assign head_next  = head_reg + TAG_W'(retire_num);
  assign tail_next  = tail_reg + TAG_W'(alloc_fire);
  assign count_next = count_reg + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire_num);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic       alloc_hit, retire_hit, complete_hit;
      rob_entry_t entry_next;

      assign alloc_hit    = alloc_fire && (tail_reg == TAG_W'(gi));
      assign retire_hit   = (r1 && (head_reg == TAG_W'(gi))) || (r2 && (head_plus1 == TAG_W'(gi)));
      assign complete_hit = (bus.complete_valid1 && (bus.complete_tag1 == TAG_W'(gi)))
                         || (bus.complete_valid2 && (bus.complete_tag2 == TAG_W'(gi)));

      // Allocation wins over a same-cycle completion: the slot is not yet valid.
      always_comb begin
        entry_next = entries_reg[gi];
        if (alloc_hit) begin
          entry_next.valid       = 1'b1;
          entry_next.done        = 1'b0;
          entry_next.is_store    = bus.alloc_is_store;
          entry_next.phys_rd     = bus.alloc_phys_rd;
          entry_next.old_phys_rd = bus.alloc_old_phys_rd;
          entry_next.arch_reg    = bus.alloc_arch_reg;
        end else if (retire_hit) begin
          entry_next.valid = 1'b0;
          entry_next.done  = 1'b0;
        end else if (complete_hit && entries_reg[gi].valid) begin
          entry_next.done = 1'b1;
        end
      end

      assign entries_next[gi] = entry_next;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_reg[i].valid <= 1'b0;
        entries_reg[i].done  <= 1'b0;
      end
      head_reg          <= '0;
      tail_reg          <= '0;
      count_reg         <= '0;
      retire_valid1_reg <= 1'b0;
      retire_valid2_reg <= 1'b0;
      retire_phys1_reg  <= NO_REG;
      retire_phys2_reg  <= NO_REG;
      retire_count_reg  <= 2'd0;
    end else begin
      entries_reg       <= entries_next;
      head_reg          <= head_next;
      tail_reg          <= tail_next;
      count_reg         <= count_next;
      retire_valid1_reg <= free1;
      retire_valid2_reg <= free2;
      retire_phys1_reg  <= free1 ? entries_reg[head_reg].old_phys_rd : NO_REG;
      retire_phys2_reg  <= free2 ? entries_reg[head_plus1].old_phys_rd : NO_REG;
      retire_count_reg  <= retire_num;
    end
  end

  assign bus.alloc_ready      = !full;
  assign bus.alloc_tag        = tail_reg;
  assign bus.retire_valid1    = retire_valid1_reg;
  assign bus.retire_phys_reg1 = retire_phys1_reg;
  assign bus.retire_valid2    = retire_valid2_reg;
  assign bus.retire_phys_reg2 = retire_phys2_reg;
  assign bus.retire_count     = retire_count_reg;
  assign bus.rob_count        = count_reg;
  assign bus.rob_empty        = (count_reg == '0);
  assign bus.rob_full         = full;
endmodule

// File: tb/tb_rob_retire_queue.sv
// Bench for rob_retire_queue: directed scenarios plus a randomized run, all
// checked against a program-order queue model of the reorder buffer.
module tb_rob_retire_queue;
  import rob_retire_queue_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rob_retire_queue_if #(.TAG_W(4)) bus ();

  rob_retire_queue #(.DEPTH(16), .TAG_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [5:0] old;
    logic       st;
    logic       done;
  } mentry_t;

  mentry_t    mq[$];
  int         m_head;
  logic       exp_rv1, exp_rv2;
  logic [5:0] exp_rp1, exp_rp2;
  int         exp_rc;
  int         n_cmp = 0;
  int         n_fail = 0;

  // One clock of stimulus; the model advances by the same rules the ROB obeys.
  task automatic drive_cycle(input logic av, input logic [5:0] old, input logic st,
                             input logic cv1, input logic [3:0] ct1,
                             input logic cv2, input logic [3:0] ct2);
    int n, off, size;
    mentry_t e;
    bus.alloc_valid       = av;
    bus.alloc_phys_rd     = st ? NO_REG : 6'($urandom_range(0, 62));
    bus.alloc_old_phys_rd = old;
    bus.alloc_arch_reg    = st ? ARCH_NONE : 5'($urandom_range(0, 30));
    bus.alloc_is_store    = st;
    bus.complete_valid1   = cv1;
    bus.complete_tag1     = ct1;
    bus.complete_valid2   = cv2;
    bus.complete_tag2     = ct2;
    size = mq.size();
    n = 0;
    if (size > 0 && mq[0].done) n = 1;
    if (n == 1 && size > 1 && mq[1].done) n = 2;
    exp_rc = n;
    exp_rv1 = 1'b0; exp_rp1 = NO_REG;
    exp_rv2 = 1'b0; exp_rp2 = NO_REG;
    if (n >= 1 && !mq[0].st && mq[0].old != NO_REG) begin exp_rv1 = 1'b1; exp_rp1 = mq[0].old; end
    if (n == 2 && !mq[1].st && mq[1].old != NO_REG) begin exp_rv2 = 1'b1; exp_rp2 = mq[1].old; end
    if (cv1) begin off = (int'(ct1) - m_head + 16) % 16; if (off < size) mq[off].done = 1'b1; end
    if (cv2) begin off = (int'(ct2) - m_head + 16) % 16; if (off < size) mq[off].done = 1'b1; end
    for (int k = 0; k < n; k++) void'(mq.pop_front());
    m_head = (m_head + n) % 16;
    if (av && size < 16) begin e.old = old; e.st = st; e.done = 1'b0; mq.push_back(e); end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive_cycle(1'b0, 6'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
  endtask

  task automatic do_reset();
    bus.alloc_valid = 1'b0; bus.complete_valid1 = 1'b0; bus.complete_valid2 = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete(); m_head = 0;
    exp_rv1 = 1'b0; exp_rv2 = 1'b0; exp_rp1 = NO_REG; exp_rp2 = NO_REG; exp_rc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.rob_empty !== 1'b1 || bus.rob_count !== 5'd0 || bus.rob_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: empty=%0b count=%0d full=%0b, want 1/0/0", bus.rob_empty, bus.rob_count, bus.rob_full);
    end
    n_cmp++;
    if (bus.alloc_ready !== 1'b1 || bus.alloc_tag !== 4'd0) begin
      n_fail++; $display("FAIL reset_alloc: ready=%0b tag=%0d, want 1/0", bus.alloc_ready, bus.alloc_tag);
    end
    n_cmp++;
    if (bus.retire_valid1 !== 1'b0 || bus.retire_valid2 !== 1'b0 || bus.retire_phys_reg1 !== NO_REG
        || bus.retire_phys_reg2 !== NO_REG || bus.retire_count !== 2'd0) begin
      n_fail++; $display("FAIL reset_retire: v1=%0b r1=%0d v2=%0b r2=%0d cnt=%0d, want 0/63/0/63/0", bus.retire_valid1,
                         bus.retire_phys_reg1, bus.retire_valid2, bus.retire_phys_reg2, bus.retire_count);
    end
    $display("test_reset done");
  endtask

  task automatic test_pair_retire();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.alloc_tag !== 4'(i)) begin n_fail++; $display("FAIL pair_tag%0d: got %0d want %0d", i, bus.alloc_tag, i); end
      drive_cycle(1'b1, 6'(5 + i), 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    end
    drive_cycle(1'b0, 6'd0, 1'b0, 1'b1, 4'd1, 1'b1, 4'd0);
    n_cmp++;
    if (bus.retire_count !== 2'd0) begin n_fail++; $display("FAIL pair_same_cycle: cnt=%0d want 0", bus.retire_count); end
    idle();
    n_cmp++;
    if (bus.retire_valid1 !== 1'b1 || bus.retire_phys_reg1 !== 6'd5 || bus.retire_valid2 !== 1'b1
        || bus.retire_phys_reg2 !== 6'd6 || bus.retire_count !== 2'd2 || bus.rob_count !== 5'd1) begin
      n_fail++; $display("FAIL pair_retire: v1=%0b r1=%0d v2=%0b r2=%0d cnt=%0d occ=%0d, want 1/5/1/6/2/1", bus.retire_valid1,
                         bus.retire_phys_reg1, bus.retire_valid2, bus.retire_phys_reg2, bus.retire_count, bus.rob_count);
    end
    $display("test_pair_retire done");
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 6'(10 + i), 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    drive_cycle(1'b0, 6'd0, 1'b0, 1'b1, 4'd2, 1'b0, 4'd0);
    idle(); idle();
    n_cmp++;
    if (bus.retire_count !== 2'd0 || bus.rob_count !== 5'd3) begin
      n_fail++; $display("FAIL ooo_blocked: cnt=%0d occ=%0d, want 0/3", bus.retire_count, bus.rob_count);
    end
    drive_cycle(1'b0, 6'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
    idle();
    n_cmp++;
    if (bus.retire_count !== 2'd1 || bus.retire_valid1 !== 1'b1 || bus.retire_phys_reg1 !== 6'd10 || bus.retire_valid2 !== 1'b0) begin
      n_fail++; $display("FAIL ooo_single: cnt=%0d v1=%0b r1=%0d v2=%0b, want 1/1/10/0", bus.retire_count,
                         bus.retire_valid1, bus.retire_phys_reg1, bus.retire_valid2);
    end
    drive_cycle(1'b0, 6'd0, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0);
    n_cmp++;
    if (bus.retire_count !== 2'd0) begin n_fail++; $display("FAIL ooo_wait: cnt=%0d want 0", bus.retire_count); end
    idle();
    n_cmp++;
    if (bus.retire_count !== 2'd2 || bus.retire_phys_reg1 !== 6'd11 || bus.retire_phys_reg2 !== 6'd12 || bus.rob_empty !== 1'b1) begin
      n_fail++; $display("FAIL ooo_pair: cnt=%0d r1=%0d r2=%0d empty=%0b, want 2/11/12/1", bus.retire_count,
                         bus.retire_phys_reg1, bus.retire_phys_reg2, bus.rob_empty);
    end
    $display("test_out_of_order done");
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 6'(16 + i), 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    n_cmp++;
    if (bus.rob_full !== 1'b1 || bus.alloc_ready !== 1'b0 || bus.rob_count !== 5'd16) begin
      n_fail++; $display("FAIL full_state: full=%0b ready=%0b occ=%0d, want 1/0/16", bus.rob_full, bus.alloc_ready, bus.rob_count);
    end
    drive_cycle(1'b1, 6'd40, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    n_cmp++;
    if (bus.rob_count !== 5'd16 || bus.alloc_tag !== 4'd0) begin
      n_fail++; $display("FAIL full_drop: occ=%0d tag=%0d, want 16/0", bus.rob_count, bus.alloc_tag);
    end
    drive_cycle(1'b0, 6'd0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0);
    drive_cycle(1'b1, 6'd41, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    n_cmp++;
    if (bus.rob_count !== 5'd15 || bus.retire_count !== 2'd1 || bus.retire_phys_reg1 !== 6'd16
        || bus.alloc_ready !== 1'b1 || bus.alloc_tag !== 4'd0) begin
      n_fail++; $display("FAIL full_retire_alloc: occ=%0d cnt=%0d r1=%0d ready=%0b tag=%0d, want 15/1/16/1/0",
                         bus.rob_count, bus.retire_count, bus.retire_phys_reg1, bus.alloc_ready, bus.alloc_tag);
    end
    drive_cycle(1'b1, 6'd42, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    n_cmp++;
    if (bus.rob_count !== 5'd16 || bus.rob_full !== 1'b1 || bus.alloc_tag !== 4'd1) begin
      n_fail++; $display("FAIL full_wrap: occ=%0d full=%0b tag=%0d, want 16/1/1", bus.rob_count, bus.rob_full, bus.alloc_tag);
    end
    $display("test_full done");
  endtask

  task automatic test_store();
    do_reset();
    drive_cycle(1'b1, NO_REG, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    drive_cycle(1'b1, 6'd9, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    drive_cycle(1'b0, 6'd0, 1'b0, 1'b1, 4'd0, 1'b1, 4'd1);
    idle();
    n_cmp++;
    if (bus.retire_count !== 2'd2 || bus.retire_valid1 !== 1'b0 || bus.retire_phys_reg1 !== NO_REG
        || bus.retire_valid2 !== 1'b1 || bus.retire_phys_reg2 !== 6'd9) begin
      n_fail++; $display("FAIL store_retire: cnt=%0d v1=%0b r1=%0d v2=%0b r2=%0d, want 2/0/63/1/9", bus.retire_count,
                         bus.retire_valid1, bus.retire_phys_reg1, bus.retire_valid2, bus.retire_phys_reg2);
    end
    $display("test_store done");
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 6'(20 + i), 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    drive_cycle(1'b0, 6'd0, 1'b0, 1'b1, 4'd0, 1'b1, 4'd1);
    do_reset();
    n_cmp++;
    if (bus.rob_empty !== 1'b1 || bus.rob_count !== 5'd0 || bus.retire_count !== 2'd0
        || bus.retire_valid1 !== 1'b0 || bus.retire_phys_reg1 !== NO_REG) begin
      n_fail++; $display("FAIL midreset_clear: empty=%0b occ=%0d cnt=%0d v1=%0b r1=%0d, want 1/0/0/0/63",
                         bus.rob_empty, bus.rob_count, bus.retire_count, bus.retire_valid1, bus.retire_phys_reg1);
    end
    idle();
    n_cmp++;
    if (bus.retire_count !== 2'd0 || bus.retire_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL midreset_next: cnt=%0d v1=%0b, want 0/0", bus.retire_count, bus.retire_valid1);
    end
    drive_cycle(1'b0, 6'd0, 1'b0, 1'b1, 4'd2, 1'b1, 4'd3);
    idle();
    n_cmp++;
    if (bus.retire_count !== 2'd0 || bus.rob_empty !== 1'b1 || bus.alloc_tag !== 4'd0) begin
      n_fail++; $display("FAIL midreset_stale: cnt=%0d empty=%0b tag=%0d, want 0/1/0", bus.retire_count, bus.rob_empty, bus.alloc_tag);
    end
    $display("test_reset_midflight done");
  endtask

  task automatic test_random();
    logic       av, st, cv1, cv2;
    logic [5:0] old;
    int         exp_size;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_size = mq.size();
      n_cmp++;
      if (bus.rob_count !== 5'(exp_size) || bus.alloc_ready !== (exp_size < 16) || bus.rob_full !== (exp_size == 16)
          || bus.rob_empty !== (exp_size == 0) || bus.alloc_tag !== 4'((m_head + exp_size) % 16)) begin
        n_fail++; $display("FAIL rand_status cyc%0d: occ=%0d ready=%0b tag=%0d, want %0d/%0b/%0d", cyc, bus.rob_count,
                           bus.alloc_ready, bus.alloc_tag, exp_size, exp_size < 16, (m_head + exp_size) % 16);
      end
      n_cmp++;
      if (bus.retire_valid1 !== exp_rv1 || bus.retire_phys_reg1 !== exp_rp1 || bus.retire_valid2 !== exp_rv2
          || bus.retire_phys_reg2 !== exp_rp2 || bus.retire_count !== 2'(exp_rc)) begin
        n_fail++; $display("FAIL rand_retire cyc%0d: v1=%0b r1=%0d v2=%0b r2=%0d cnt=%0d, want %0b/%0d/%0b/%0d/%0d", cyc,
                           bus.retire_valid1, bus.retire_phys_reg1, bus.retire_valid2, bus.retire_phys_reg2,
                           bus.retire_count, exp_rv1, exp_rp1, exp_rv2, exp_rp2, exp_rc);
      end
      av  = ($urandom_range(0, 99) < 60);
      st  = ($urandom_range(0, 99) < 20);
      old = st ? NO_REG : 6'($urandom_range(0, 63));
      cv1 = ($urandom_range(0, 99) < 50);
      cv2 = ($urandom_range(0, 99) < 35);
      drive_cycle(av, old, st, cv1, 4'($urandom_range(0, 15)), cv2, 4'($urandom_range(0, 15)));
    end
    $display("test_random done");
  endtask

  initial begin
    bus.alloc_valid = 1'b0; bus.alloc_phys_rd = '0; bus.alloc_old_phys_rd = '0; bus.alloc_arch_reg = '0;
    bus.alloc_is_store = 1'b0; bus.complete_valid1 = 1'b0; bus.complete_tag1 = '0;
    bus.complete_valid2 = 1'b0; bus.complete_tag2 = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_pair_retire();
    test_out_of_order();
    test_full();
    test_store();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
